// File: rtl/opb_s2p_pkg.sv
// ---------------------------------------------------------------------------
// opb_s2p_pkg
// Shared definitions for the Simulink-to-PPC OPB register slave:
//   - byte offsets of the three software-visible registers inside the window
//   - bit positions of the fields packed into the STATUS word
//   - encoding of the bus-handshake state machine
//   - a helper that assembles the STATUS word from its fields
// No ports; imported by opb_s2p_slave_if and opb_register_simulink2ppc.
// ---------------------------------------------------------------------------
package opb_s2p_pkg;

    // Byte offsets relative to the base of the slave window
    localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
    localparam logic [31:0] OFF_TSTAMP = 32'h0000_0008;

    // STATUS layout: NEW flag, overrun flag, 16-bit capture counter in the low half
    localparam int STATUS_NEW_BIT = 31;
    localparam int STATUS_OVR_BIT = 30;
    localparam int STATUS_CNT_MSB = 15;

    // Handshake states: wait for a hit, acknowledge once, then wait for deselect
    typedef enum logic [1:0] {
        S2P_IDLE = 2'd0,
        S2P_ACK  = 2'd1,
        S2P_HOLD = 2'd2
    } s2pState_t;

    // Packs the individual status fields into the word software reads
    function automatic logic [31:0] statusWord(
        input logic        newFlag,
        input logic        ovrFlag,
        input logic [15:0] count
    );
        logic [31:0] word;
        word                   = '0;
        word[STATUS_NEW_BIT]   = newFlag;
        word[STATUS_OVR_BIT]   = ovrFlag;
        word[STATUS_CNT_MSB:0] = count;
        return word;
    endfunction

endpackage

// File: rtl/opb_s2p_slave_if.sv
// ---------------------------------------------------------------------------
// opb_s2p_slave_if
// OPB slave handshake: address-window decode, the IDLE/ACK/HOLD state
// machine and the one-cycle transfer acknowledge.
// Ports:
//   i_clk, i_rst   clock and asynchronous active-high reset
//   i_abus         byte address from the bus (MSB first)
//   i_select       OPB select qualifier
//   o_start        high in the cycle whose closing edge snapshots the access
//   o_ack          transfer acknowledge, high for exactly one cycle per access
//   o_offset       byte offset of i_abus from the window base
// ---------------------------------------------------------------------------
module opb_s2p_slave_if
    import opb_s2p_pkg::*;
#(
    parameter int unsigned      AW        = 32,
    parameter logic [AW-1:0]    BASE_ADDR = 32'h0106_0700,
    parameter logic [AW-1:0]    HIGH_ADDR = 32'h0106_07FF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_abus,
    input  logic          i_select,
    output logic          o_start,
    output logic          o_ack,
    output logic [AW-1:0] o_offset
);

    s2pState_t r_state;
    s2pState_t w_nextState;
    logic      w_hit;

    // A hit needs select plus an address inside the inclusive window bounds
    assign w_hit    = i_select && (i_abus >= BASE_ADDR) && (i_abus <= HIGH_ADDR);
    assign o_offset = i_abus - BASE_ADDR;

    // State register; reset drops straight back to IDLE so any
    // in-flight acknowledge disappears without waiting for a clock
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S2P_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs. o_start marks the IDLE cycle that
    // sees a hit; the register block snapshots on that edge. HOLD waits
    // for the master to drop select so one long select yields one ack.
    always_comb begin
        w_nextState = r_state;
        o_start     = 1'b0;
        o_ack       = 1'b0;
        case (r_state)
            S2P_IDLE: begin
                if (w_hit) begin
                    o_start     = 1'b1;
                    w_nextState = S2P_ACK;
                end
            end
            S2P_ACK: begin
                o_ack       = 1'b1;
                w_nextState = S2P_HOLD;
            end
            S2P_HOLD: begin
                if (!i_select) begin
                    w_nextState = S2P_IDLE;
                end
            end
            default: begin
                w_nextState = S2P_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// ---------------------------------------------------------------------------
// opb_register_simulink2ppc
// Publishes a fabric value to software over OPB. The fabric strobes
// user_valid to capture user_data_in; software reads DATA (0x0), STATUS (0x4)
// and, when built with macro OPB_S2P_TIMESTAMP_EN, TSTAMP (0x8) holding the
// free-running cycle count latched at the last capture. Without the macro,
// 0x8 is acknowledged and reads as zero.
// Ports:
//   OPB_Clk, OPB_Rst        clock, asynchronous active-high reset
//   OPB_ABus/BE/DBus/RNW    OPB address, byte enables, write data, direction
//   OPB_select, OPB_seqAddr transfer qualifiers (seqAddr is not used)
//   Sl_DBus, Sl_xferAck     read data (zero outside the ack cycle), ack
//   Sl_errAck/retry/toutSup always zero
//   user_data_in, user_valid fabric capture value and strobe
// ---------------------------------------------------------------------------
module opb_register_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h0106_0700,
    parameter logic [31:0] C_HIGHADDR   = 32'h0106_07FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    input  logic [31:0]                 user_data_in,
    input  logic                        user_valid
);
    import opb_s2p_pkg::*;

    // The family string is informational only for this slave
    localparam bit w_unusedFamilyIsV5 = (C_FAMILY == "virtex5");

    logic                    w_start;
    logic                    w_ack;
    logic [C_OPB_AWIDTH-1:0] w_offset;
    logic [31:0]             w_rdData;
    logic [31:0]             w_tstamp;
    logic                    w_readHit;
    logic                    w_statusWrite;
    logic                    w_clrNew;
    logic                    w_clrOvr;
    logic                    w_unused;

    logic [31:0] r_data;
    logic        r_new;
    logic        r_ovr;
    logic [15:0] r_count;
    logic [31:0] r_readData;

    // Only the top two write-data bits and the first byte enable matter
    assign w_unused = ^{OPB_seqAddr, OPB_BE[1:C_OPB_DWIDTH/8-1], OPB_DBus[2:C_OPB_DWIDTH-1]};

    opb_s2p_slave_if #(
        .AW        (C_OPB_AWIDTH),
        .BASE_ADDR (C_BASEADDR[C_OPB_AWIDTH-1:0]),
        .HIGH_ADDR (C_HIGHADDR[C_OPB_AWIDTH-1:0])
    ) u_slaveIf (
        .i_clk    (OPB_Clk),
        .i_rst    (OPB_Rst),
        .i_abus   (OPB_ABus),
        .i_select (OPB_select),
        .o_start  (w_start),
        .o_ack    (w_ack),
        .o_offset (w_offset)
    );

    // Side effects are taken on the snapshot edge so that a capture on the
    // same edge naturally overrides a NEW clear. Status writes only act
    // when the top byte lane is enabled; bus bit 0 is word bit 31.
    assign w_readHit     = w_start && OPB_RNW;
    assign w_statusWrite = w_start && !OPB_RNW && (w_offset == OFF_STATUS) && OPB_BE[0];
    assign w_clrNew      = (w_readHit && (w_offset == OFF_DATA)) || (w_statusWrite && OPB_DBus[0]);
    assign w_clrOvr      = w_statusWrite && OPB_DBus[1];

    // Read mux over the current (pre-edge) register values; unmapped
    // offsets inside the window read as zero
    always_comb begin
        w_rdData = '0;
        case (w_offset)
            OFF_DATA:   w_rdData = r_data;
            OFF_STATUS: w_rdData = statusWord(r_new, r_ovr, r_count);
            OFF_TSTAMP: w_rdData = w_tstamp;
            default:    w_rdData = '0;
        endcase
    end

    // Capture path and status flags. OVR looks at NEW before this edge,
    // and a capture always leaves NEW set even if software cleared it now.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_data  <= '0;
            r_new   <= 1'b0;
            r_ovr   <= 1'b0;
            r_count <= '0;
        end else begin
            if (user_valid) begin
                r_data  <= user_data_in;
                r_count <= r_count + 16'd1;
            end
            r_new <= user_valid || (r_new && !w_clrNew);
            r_ovr <= (user_valid && r_new) || (r_ovr && !w_clrOvr);
        end
    end

    // Read snapshot taken on the hit edge and held through the ack cycle;
    // writes load zero so nothing leaks onto the bus
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_readData <= '0;
        end else if (w_start) begin
            r_readData <= OPB_RNW ? w_rdData : 32'h0;
        end
    end

`ifdef OPB_S2P_TIMESTAMP_EN
    logic [31:0] r_cycleCount;
    logic [31:0] r_tstamp;

    // Free-running cycle counter, latched into TSTAMP on each capture
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_cycleCount <= '0;
            r_tstamp     <= '0;
        end else begin
            r_cycleCount <= r_cycleCount + 32'd1;
            if (user_valid) begin
                r_tstamp <= r_cycleCount;
            end
        end
    end

    assign w_tstamp = r_tstamp;
`else
    assign w_tstamp = '0;
`endif

    // OR-bus etiquette: data is driven only while acknowledging
    assign Sl_xferAck = w_ack;
    assign Sl_DBus    = w_ack ? r_readData : '0;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// ---------------------------------------------------------------------------
// tb_opb_register_simulink2ppc
// Directed bench for the Simulink-to-PPC OPB register slave. Drives OPB
// transfers and fabric captures and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_opb_register_simulink2ppc;

    localparam logic [31:0] BASE = 32'h0106_0700;

    logic        OPB_Clk;
    logic        OPB_Rst;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic [31:0] user_data_in;
    logic        user_valid;

    int checks   = 0;
    int failures = 0;
    int tbCycles = 0;

    opb_register_simulink2ppc dut (
        .OPB_Clk      (OPB_Clk),
        .OPB_Rst      (OPB_Rst),
        .OPB_ABus     (OPB_ABus),
        .OPB_BE       (OPB_BE),
        .OPB_DBus     (OPB_DBus),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_seqAddr  (OPB_seqAddr),
        .Sl_DBus      (Sl_DBus),
        .Sl_xferAck   (Sl_xferAck),
        .Sl_errAck    (Sl_errAck),
        .Sl_retry     (Sl_retry),
        .Sl_toutSup   (Sl_toutSup),
        .user_data_in (user_data_in),
        .user_valid   (user_valid)
    );

    // 100 MHz clock
    initial OPB_Clk = 1'b0;
    always #5 OPB_Clk = ~OPB_Clk;

    // Count of clock edges since reset release, i.e. the expected timestamp
    always @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) tbCycles <= 0;
        else         tbCycles <= tbCycles + 1;
    end

    // One comparison: counts it and reports any difference
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Holds reset for two edges and releases it just after an edge
    task automatic doReset();
        OPB_Rst = 1'b1;
        repeat (2) @(posedge OPB_Clk);
        #1;
        OPB_Rst = 1'b0;
    endtask

    // Strobes user_valid for n consecutive edges with a fixed value
    task automatic pulseCapture(input logic [31:0] value, input int n);
        user_valid   = 1'b1;
        user_data_in = value;
        repeat (n) @(posedge OPB_Clk);
        #1;
        user_valid = 1'b0;
    endtask

    // One OPB transfer, bounded to five edges of select; counts acks and
    // any non-zero read data seen outside an ack cycle
    task automatic applyStimulus(
        input  logic [31:0] addr,
        input  logic        rnw,
        input  logic [3:0]  be,
        input  logic [31:0] wdata,
        input  logic        capAlong,
        input  logic [31:0] capData,
        output logic [31:0] rdata,
        output int          acks,
        output int          stray
    );
        OPB_ABus   = addr;
        OPB_RNW    = rnw;
        OPB_BE     = be;
        OPB_DBus   = wdata;
        OPB_select = 1'b1;
        if (capAlong) begin
            user_valid   = 1'b1;
            user_data_in = capData;
        end
        acks  = 0;
        stray = 0;
        rdata = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge OPB_Clk);
            #1;
            user_valid = 1'b0;
            if (Sl_xferAck) begin
                acks++;
                rdata      = Sl_DBus;
                OPB_select = 1'b0;
            end else if (Sl_DBus !== 32'h0) begin
                stray++;
            end
        end
        OPB_select = 1'b0;
        OPB_RNW    = 1'b0;
        OPB_ABus   = '0;
        OPB_BE     = '0;
        OPB_DBus   = '0;
        repeat (2) @(posedge OPB_Clk);
        #1;
    endtask

    // Acked read with one ack, a clean bus otherwise, and the given value
    task automatic readCheck(input string tag, input logic [31:0] offset, input logic [31:0] expected);
        logic [31:0] rd;
        int          acks;
        int          stray;
        applyStimulus(BASE + offset, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0, rd, acks, stray);
        checkOutput({tag, "_data"}, rd, expected);
        checkOutput({tag, "_acks"}, acks, 32'd1);
        checkOutput({tag, "_stray"}, stray, 32'd0);
    endtask

    // Acked write with exactly one ack
    task automatic writeCheck(input string tag, input logic [31:0] offset, input logic [3:0] be, input logic [31:0] wdata);
        logic [31:0] rd;
        int          acks;
        int          stray;
        applyStimulus(BASE + offset, 1'b0, be, wdata, 1'b0, 32'h0, rd, acks, stray);
        checkOutput({tag, "_acks"}, acks, 32'd1);
    endtask

    logic [31:0] rd;
    int          acks;
    int          stray;
    int          tsExpected;

    // Directed sequence
    initial begin
        OPB_Rst      = 1'b1;
        OPB_ABus     = '0;
        OPB_BE       = '0;
        OPB_DBus     = '0;
        OPB_RNW      = 1'b0;
        OPB_select   = 1'b0;
        OPB_seqAddr  = 1'b0;
        user_data_in = '0;
        user_valid   = 1'b0;

        $display("[TB] reset state");
        doReset();
        checkOutput("rst_ack", Sl_xferAck, 32'd0);
        checkOutput("rst_dbus", Sl_DBus, 32'h0);
        checkOutput("rst_tied", {Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);
        readCheck("rst_status", 32'h4, 32'h0000_0000);
        readCheck("rst_data", 32'h0, 32'h0000_0000);

        $display("[TB] capture and read DATA");
        pulseCapture(32'hDEAD_BEEF, 1);
        readCheck("data_deadbeef", 32'h0, 32'hDEAD_BEEF);

        $display("[TB] NEW flag set by capture, cleared by DATA read");
        doReset();
        pulseCapture(32'h1, 1);
        readCheck("status_new", 32'h4, 32'h8000_0001);
        readCheck("data_one", 32'h0, 32'h0000_0001);
        readCheck("status_cleared", 32'h4, 32'h0000_0001);

        $display("[TB] overrun and W1C");
        doReset();
        pulseCapture(32'h11, 1);
        pulseCapture(32'h22, 1);
        readCheck("status_ovr", 32'h4, 32'hC000_0002);
        writeCheck("w1c_ovr", 32'h4, 4'hF, 32'h4000_0000);
        readCheck("status_after_ovr_clr", 32'h4, 32'h8000_0002);
        writeCheck("w1c_be0", 32'h4, 4'h0, 32'h8000_0000);
        readCheck("status_be0_ignored", 32'h4, 32'h8000_0002);
        writeCheck("w1c_new", 32'h4, 4'h8, 32'h8000_0000);
        readCheck("status_after_new_clr", 32'h4, 32'h0000_0002);

        $display("[TB] capture coincident with DATA read");
        doReset();
        pulseCapture(32'h4, 1);
        applyStimulus(BASE, 1'b1, 4'h0, 32'h0, 1'b1, 32'h5, rd, acks, stray);
        checkOutput("coinc_data", rd, 32'h4);
        checkOutput("coinc_acks", acks, 32'd1);
        readCheck("coinc_status", 32'h4, 32'hC000_0002);
        readCheck("coinc_newdata", 32'h0, 32'h5);
        readCheck("coinc_status_after", 32'h4, 32'h4000_0002);
        writeCheck("data_ro_write", 32'h0, 4'hF, 32'hFFFF_FFFF);
        readCheck("data_ro_unchanged", 32'h0, 32'h5);

        $display("[TB] timestamp and unmapped offsets");
`ifdef OPB_S2P_TIMESTAMP_EN
        tsExpected = tbCycles;
`else
        tsExpected = 0;
`endif
        pulseCapture(32'h77, 1);
        readCheck("tstamp", 32'h8, tsExpected);
        readCheck("unmapped_c", 32'hC, 32'h0);

        $display("[TB] addresses outside the window");
        applyStimulus(BASE + 32'h100, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0, rd, acks, stray);
        checkOutput("miss_high_acks", acks, 32'd0);
        checkOutput("miss_high_stray", stray, 32'd0);
        applyStimulus(BASE - 32'h4, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0, rd, acks, stray);
        checkOutput("miss_low_acks", acks, 32'd0);
        checkOutput("miss_low_stray", stray, 32'd0);

        $display("[TB] reset during ACK");
        pulseCapture(32'hA5A5_A5A5, 1);
        OPB_ABus   = BASE;
        OPB_RNW    = 1'b1;
        OPB_select = 1'b1;
        @(posedge OPB_Clk);
        #1;
        checkOutput("pre_abort_ack", Sl_xferAck, 32'd1);
        checkOutput("pre_abort_data", Sl_DBus, 32'hA5A5_A5A5);
        OPB_Rst = 1'b1;
        #1;
        checkOutput("abort_ack", Sl_xferAck, 32'd0);
        checkOutput("abort_dbus", Sl_DBus, 32'h0);
        @(posedge OPB_Clk);
        #1;
        OPB_Rst = 1'b0;
        @(posedge OPB_Clk);
        #1;
        checkOutput("rehit_ack", Sl_xferAck, 32'd1);
        checkOutput("rehit_data", Sl_DBus, 32'h0);
        OPB_select = 1'b0;
        OPB_RNW    = 1'b0;
        OPB_ABus   = '0;
        repeat (2) @(posedge OPB_Clk);
        #1;
        checkOutput("rehit_idle_ack", Sl_xferAck, 32'd0);

        $display("[TB] capture counter wrap");
        doReset();
        pulseCapture(32'h1234, 65535);
        readCheck("cnt_ffff", 32'h4, 32'hC000_FFFF);
        pulseCapture(32'h1235, 1);
        readCheck("cnt_wrap", 32'h4, 32'hC000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opb_register_simulink2ppc.md
OPB_REGISTER_SIMULINK2PPC -- requirements
Module: opb_register_simulink2ppc

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h01060700, first byte address of the slave window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h010607FF, last byte address of the slave window.
REQ-003 SHALL have parameters C_OPB_AWIDTH=32, C_OPB_DWIDTH=32 and C_FAMILY="virtex5", giving the bus widths and target family.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 OPB_Clk  in  1  sole clock; all state is rising-edge.
REQ-006 OPB_Rst  in  1  asynchronous active-high reset.
REQ-007 OPB_ABus  in  [0:31]  byte address.
REQ-008 OPB_BE  in  [0:3]  byte enables, used on status writes only.
REQ-009 OPB_DBus  in  [0:31]  write data.
REQ-010 OPB_RNW  in  1  1=read, 0=write.
REQ-011 OPB_select, OPB_seqAddr  in  1 each  transfer qualifier; seqAddr ignored.
REQ-012 Sl_DBus  out  [0:31]  read data, all-zero whenever Sl_xferAck=0 (OR-bus rule).
REQ-013 Sl_xferAck  out  1  one-cycle transfer acknowledge.
REQ-014 Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0.
REQ-015 user_data_in  in  [31:0]  fabric value to publish to software.
REQ-016 user_valid  in  1  capture strobe for user_data_in.

Function
REQ-017 Hit = OPB_select & (OPB_ABus within C_BASEADDR..C_HIGHADDR); offsets: 0x0 DATA (RO), 0x4 STATUS, 0x8 TSTAMP (macro only).
REQ-018 user_valid=1 on an edge SHALL load DATA with user_data_in; DATA bit 31 maps to Sl_DBus[0].
REQ-019 STATUS word: bit31 NEW (set on capture), bit30 OVR (set on capture while NEW=1), bits15:0 CNT (capture count, wraps 0xFFFF->0x0000), others 0.
REQ-020 FSM states: IDLE, ACK, HOLD.
REQ-021 IDLE->ACK on hit; the selected register is snapshotted on that edge.
REQ-022 ACK lasts exactly one cycle with Sl_xferAck=1 (latency: ack in the 2nd cycle of select), then goes to HOLD.
REQ-023 HOLD->IDLE when OPB_select=0; no new ack may occur in HOLD.
REQ-024 An acked read of DATA SHALL clear NEW; a read of STATUS clears nothing.
REQ-025 An acked write to STATUS with OPB_BE[0]=1 SHALL clear NEW where OPB_DBus[0]=1 and OVR where OPB_DBus[1]=1 (W1C); other writes are acked and discarded.
REQ-026 If a capture and a NEW-clearing event fall on the same edge, the capture wins: NEW=1, and OVR is evaluated on the pre-edge NEW.
REQ-027 A read that coincides with a capture SHALL return the pre-capture snapshot.
REQ-028 Non-hit or deselected cycles SHALL leave all outputs at 0.

Reset
REQ-029 Assertion of OPB_Rst SHALL immediately force FSM=IDLE, Sl_xferAck=0, Sl_DBus=0, DATA=0, NEW=OVR=0, CNT=0, TSTAMP counter=0.
REQ-030 Reset mid-transfer SHALL abort without an ack; after release, a still-asserted select is treated as a new hit.

Configuration
REQ-031 Macro OPB_S2P_TIMESTAMP_EN defined: a free-running 32-bit cycle counter (wrapping) is latched into TSTAMP on each capture and is readable at 0x8.
REQ-032 Macro undefined: no counter is built; 0x8 is acked and reads 0.

Structure
REQ-033 Package opb_s2p_pkg SHALL hold the offset constants, the STATUS bit positions and the FSM state encoding.
REQ-034 Sub-module opb_s2p_slave_if SHALL contain the hit decode, the FSM and ack generation; the top level holds the registers and the read mux.

Verification
REQ-035 Reset, then user_valid with 0xDEADBEEF -> read 0x0 returns 0xDEADBEEF, one ack, Sl_DBus=0 on all other cycles.
REQ-036 Capture 0x1 then read 0x4 -> 0x80000001; read 0x0 then read 0x4 -> 0x00000001.
REQ-037 Two captures with no read, then read 0x4 -> 0xC0000002; write 0x4 with data 0x40000000 and BE=0xF, then read -> 0x80000002.
REQ-038 Capture 0x5 on the same edge the read of 0x0 is snapshotted (old DATA 0x4) -> returns 0x4, NEW=1 afterwards.
REQ-039 OPB_Rst asserted during ACK -> no ack, outputs 0 immediately; 65536 captures -> CNT=0x0000.
REQ-040 With OPB_S2P_TIMESTAMP_EN, capture at counter value N -> read 0x8 returns N; without the macro -> read 0x8 returns 0.
